// File: rtl/tx_os_inserter.sv
// -----------------------------------------------------------------------------
// tx_os_inserter
//
// Transmit framing stage in front of the 8-bit scrambler. After reset it emits
// one COM so the downstream LFSR synchronises. It then forwards a
// valid/ready byte stream with one cycle of latency. It fills gaps with
// logical idle and periodically inserts a SKP ordered set (COM followed by
// SKP_COUNT x SKIP) between packets.
//
// Optional build macro: TX_OS_FORCE_EN
//   When defined, a pending ordered set that has waited SKP_INTERVAL cycles
//   for a packet boundary is inserted mid-packet. The packet resumes after
//   the ordered set.
//
// Ports
//   clk                in   clock
//   rst                in   synchronous active-high reset
//   s_valid            in   upstream byte valid
//   s_ready            out  upstream byte accepted when s_valid && s_ready
//   s_data[7:0]        in   payload byte
//   s_k                in   payload byte is a control symbol
//   s_last             in   last byte of packet
//   s_dis_scrambler    in   scramble-disable for this byte (passed through)
//   dout[7:0]          out  symbol to scrambler din
//   k_out              out  to scrambler k_in
//   dis_scrambler_out  out  to scrambler dis_scrambler_in
//   err_ctrl           out  one-cycle pulse: upstream sent COM/SKIP as K symbol
// -----------------------------------------------------------------------------
module tx_os_inserter #(
  parameter logic [7:0] COM          = 8'hBC,
  parameter logic [7:0] SKIP         = 8'h1C,
  parameter int         SKP_INTERVAL = 1180,  // legal 8..65535
  parameter int         SKP_COUNT    = 3,     // legal 1..7
  parameter logic [7:0] IDLE_BYTE    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_k,
  input  logic       s_last,
  input  logic       s_dis_scrambler,
  output logic [7:0] dout,
  output logic       k_out,
  output logic       dis_scrambler_out,
  output logic       err_ctrl
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_DATA = 2'd1,
    ST_SKP  = 2'd2
  } state_t;

  localparam logic [15:0] CNT_MAX  = 16'(SKP_INTERVAL - 1);
  localparam logic [2:0]  SKP_LAST = 3'(SKP_COUNT - 1);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d, cnt_inc;
  logic        pending, pending_d;
  logic        in_pkt, in_pkt_d;
  logic [2:0]  skp_idx, skp_idx_d;
  logic [7:0]  dout_d;
  logic        k_d, dis_d, err_d;
  logic        insert, accept, force_hit;

`ifdef TX_OS_FORCE_EN
  localparam logic [15:0] FORCE_LIMIT = 16'(SKP_INTERVAL);
  logic [15:0] force_cnt, force_cnt_d;
  // The pending set has waited long enough inside a packet.
  assign force_hit = (force_cnt == FORCE_LIMIT);
`else
  assign force_hit = 1'b0;
`endif

  // Start an ordered set this cycle. This happens at a packet boundary, or
  // mid-packet once the forced-insertion timer expires.
  assign insert  = (state == ST_DATA) && pending && (!in_pkt || force_hit);
  assign s_ready = !rst && (state == ST_DATA) && !insert;
  assign accept  = s_valid && s_ready;

  // The interval counter saturates so a long packet cannot wrap it.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 16'd1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise a latch would be inferred.
    state_d   = state;
    cnt_d     = cnt;
    pending_d = pending;
    in_pkt_d  = in_pkt;
    skp_idx_d = skp_idx;
    dout_d    = IDLE_BYTE;
    k_d       = 1'b0;
    dis_d     = 1'b0;
    err_d     = 1'b0;
`ifdef TX_OS_FORCE_EN
    force_cnt_d = force_cnt;
`endif

    unique case (state)
      ST_SYNC: begin
        dout_d    = COM;
        k_d       = 1'b1;
        cnt_d     = '0;
        pending_d = 1'b0;
        state_d   = ST_DATA;
      end

      ST_DATA: begin
        if (insert) begin
          dout_d    = COM;
          k_d       = 1'b1;
          skp_idx_d = '0;
          cnt_d     = '0;
          pending_d = 1'b0;
          state_d   = ST_SKP;
`ifdef TX_OS_FORCE_EN
          force_cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) pending_d = 1'b1;
`ifdef TX_OS_FORCE_EN
          if (pending && in_pkt) force_cnt_d = force_cnt + 16'd1;
`endif
          if (accept) begin
            dout_d   = s_data;
            k_d      = s_k;
            dis_d    = s_dis_scrambler;
            in_pkt_d = !s_last;
            err_d    = s_k && ((s_data == COM) || (s_data == SKIP));
          end
          // An underrun emits idle. in_pkt is kept, so the packet continues
          // afterwards.
        end
      end

      ST_SKP: begin
        dout_d    = SKIP;
        k_d       = 1'b1;
        skp_idx_d = skp_idx + 3'd1;
        if (skp_idx == SKP_LAST) state_d = ST_DATA;
      end

      default: state_d = ST_SYNC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_SYNC;
      cnt               <= '0;
      pending           <= 1'b0;
      in_pkt            <= 1'b0;
      skp_idx           <= '0;
      dout              <= '0;
      k_out             <= 1'b0;
      dis_scrambler_out <= 1'b0;
      err_ctrl          <= 1'b0;
`ifdef TX_OS_FORCE_EN
      force_cnt         <= '0;
`endif
    end else begin
      state             <= state_d;
      cnt               <= cnt_d;
      pending           <= pending_d;
      in_pkt            <= in_pkt_d;
      skp_idx           <= skp_idx_d;
      dout              <= dout_d;
      k_out             <= k_d;
      dis_scrambler_out <= dis_d;
      err_ctrl          <= err_d;
`ifdef TX_OS_FORCE_EN
      force_cnt         <= force_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_os_inserter.sv
// -----------------------------------------------------------------------------
// tb_tx_os_inserter
//
// Self-checking bench for tx_os_inserter with SKP_INTERVAL=16, SKP_COUNT=3.
// A behavioural reference model tracks the output symbol stream. It counts
// DATA symbols since the last ordered set, whether an ordered set is owed,
// and how many SKIPs remain. Each cycle the model is compared with s_ready
// and with the registered outputs. Directed sequences then check exact
// symbol traces for sync, periodic insertion, packet integrity, err_ctrl
// and reset during an ordered set.
// -----------------------------------------------------------------------------
module tb_tx_os_inserter;

  localparam int         SI   = 16;
  localparam int         SC   = 3;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] SKIP = 8'h1C;
  localparam logic [7:0] IDLE = 8'h00;
`ifdef TX_OS_FORCE_EN
  localparam bit FORCE_EN = 1'b1;
`else
  localparam bit FORCE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       last;
    logic       dis;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, s_k, s_last, s_dis;
  logic [7:0] s_data, dout;
  logic       k_out, dis_out, err_ctrl;

  always #5 clk = ~clk;

  tx_os_inserter #(
    .COM(COM), .SKIP(SKIP), .SKP_INTERVAL(SI), .SKP_COUNT(SC), .IDLE_BYTE(IDLE)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_k(s_k),
    .s_last(s_last), .s_dis_scrambler(s_dis),
    .dout(dout), .k_out(k_out), .dis_scrambler_out(dis_out), .err_ctrl(err_ctrl)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit         m_sync_due;    // the post-reset COM is still owed
  int         m_skips_left;  // SKIP symbols still to emit in this ordered set
  int         m_since;       // DATA-state symbols since the last ordered set
  bit         m_need;        // an ordered set is owed
  bit         m_mid;         // upstream is inside a packet
  int         m_fw;          // cycles the owed set has waited mid-packet
  logic [7:0] m_dout;
  bit         m_k, m_dis, m_err;

  item_t      q[$];          // upstream bytes still to deliver
  logic [8:0] trace[$];      // recorded {k_out, dout}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_insert_now();
    return m_need && (!m_mid || (FORCE_EN && m_fw >= SI));
  endfunction

  function automatic bit m_ready();
    return !rst && !m_sync_due && (m_skips_left == 0) && !m_insert_now();
  endfunction

  // Advance the model by one output symbol, using the inputs present at the edge.
  task automatic model_step(input bit acc);
    m_err = 1'b0;
    m_dis = 1'b0;
    if (rst) begin
      m_sync_due = 1'b1; m_skips_left = 0; m_since = 0; m_need = 1'b0;
      m_mid = 1'b0; m_fw = 0; m_dout = 8'h00; m_k = 1'b0;
    end else if (m_sync_due) begin
      m_sync_due = 1'b0; m_since = 0; m_need = 1'b0;
      m_dout = COM; m_k = 1'b1;
    end else if (m_skips_left > 0) begin
      m_skips_left--;
      m_dout = SKIP; m_k = 1'b1;
    end else if (m_insert_now()) begin
      m_skips_left = SC; m_since = 0; m_need = 1'b0; m_fw = 0;
      m_dout = COM; m_k = 1'b1;
    end else begin
      if (m_need && m_mid) m_fw++;
      m_since = (m_since + 1 > SI - 1) ? SI - 1 : m_since + 1;
      if (m_since == SI - 1) m_need = 1'b1;
      if (acc) begin
        m_dout = s_data; m_k = s_k; m_dis = s_dis; m_mid = !s_last;
        m_err  = s_k && (s_data == COM || s_data == SKIP);
      end else begin
        m_dout = IDLE; m_k = 1'b0;
      end
    end
  endtask

  // One clock: check s_ready mid-cycle, step the model at the edge, and
  // check the registered outputs just after the edge.
  task automatic tick(output bit acc);
    bit exp_rdy;
    #1;
    exp_rdy = m_ready();
    check("s_ready", s_ready, exp_rdy);
    acc = s_valid && exp_rdy;
    @(posedge clk);
    model_step(acc);
    #1;
    check("dout", dout, m_dout);
    check("k_out", k_out, m_k);
    check("dis_out", dis_out, m_dis);
    check("err_ctrl", err_ctrl, m_err);
  endtask

  task automatic drive(input bit v);
    if (v && q.size() > 0) begin
      s_valid = 1'b1;
      {s_data, s_k, s_last, s_dis} = q[0];
    end else begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      s_k     = 1'($urandom);
      s_last  = 1'($urandom);
      s_dis   = 1'($urandom);
    end
  endtask

  // mode 1: fixed 11,22,33,44 packet; mode 2: random packet; other: nothing
  task automatic refill(input int mode);
    item_t it;
    int    len;
    if (mode == 1) begin
      q.push_back('{8'h11, 1'b0, 1'b0, 1'b0});
      q.push_back('{8'h22, 1'b0, 1'b0, 1'b0});
      q.push_back('{8'h33, 1'b0, 1'b0, 1'b0});
      q.push_back('{8'h44, 1'b0, 1'b1, 1'b0});
    end else if (mode == 2) begin
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        it.k    = ($urandom_range(0, 15) == 0);
        it.data = it.k ? (($urandom_range(0, 1) == 0) ? COM : SKIP) : 8'($urandom);
        it.dis  = ($urandom_range(0, 7) == 0);
        it.last = (i == len - 1);
        q.push_back(it);
      end
    end
  endtask

  task automatic run(input int n, input int mode, input int valid_pct, input bit record);
    bit acc;
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) refill(mode);
      drive($urandom_range(0, 99) < valid_pct);
      tick(acc);
      if (acc) void'(q.pop_front());
      if (record) trace.push_back({k_out, dout});
    end
  endtask

  // Check a trace window that starts with a COM: 15 idles, then an ordered set.
  task automatic check_os_period(input string tag);
    check({tag, "_com0"}, trace[0], {1'b1, COM});
    for (int i = 1; i < SI; i++) check({tag, "_idle"}, trace[i], {1'b1 ^ 1'b1, IDLE});
    check({tag, "_com1"}, trace[SI], {1'b1, COM});
    for (int i = 1; i <= SC; i++) check({tag, "_skip"}, trace[SI + i], {1'b1, SKIP});
    check({tag, "_idle_after"}, trace[SI + SC + 1], {1'b0, IDLE});
  endtask

  task automatic send_one(input item_t it, input bit exp_err);
    bit acc;
    int n;
    q.delete();
    q.push_back(it);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      drive(1'b1);
      tick(acc);
      n++;
    end
    q.delete();
    check("direct_accepted", acc, 1'b1);
    check("direct_dout", dout, it.data);
    check("direct_k", k_out, it.k);
    check("direct_dis", dis_out, it.dis);
    check("direct_err", err_ctrl, exp_err);
    drive(1'b0);
    tick(acc);
    check("direct_err_clear", err_ctrl, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    int first;

    // Reset with no traffic
    rst = 1'b1;
    drive(1'b0);
    for (int i = 0; i < 3; i++) tick(acc);
    check("reset_dout", dout, 8'h00);
    check("reset_ready", s_ready, 1'b0);

    // Release with s_valid=0: sync COM, 15 idles, ordered set, idle
    rst = 1'b0;
    trace.delete();
    run(45, 0, 0, 1);
    check_os_period("idle_stream");

    // Continuous 11,22,33,44 packets
    run(200, 1, 100, 0);

    // Random packets with random valid gaps, and a reset partway through
    q.delete();
    run(400, 2, 70, 0);
    rst = 1'b1;
    drive(1'b0);
    tick(acc);
    tick(acc);
    rst = 1'b0;
    q.delete();
    run(400, 2, 70, 0);

    // 40-byte packet timed so the ordered set becomes owed at byte 10
    q.delete();
    n = 0;
    drive(1'b0);
    while (!(m_skips_left == 0 && !m_sync_due && !m_need && m_since == 5) && n < 200) begin
      drive(1'b0);
      tick(acc);
      n++;
    end
    check("wait_since5_in_budget", n < 200, 1'b1);
    for (int i = 0; i < 40; i++) q.push_back('{8'(8'h40 + i), 1'b0, (i == 39), 1'b0});
    trace.delete();
    run(60, 0, 100, 1);
    first = -1;
    for (int i = 0; i < 5; i++) if (first < 0 && trace[i] == 9'h040) first = i;
    check("pkt40_found", first >= 0, 1'b1);
`ifndef TX_OS_FORCE_EN
    if (first >= 0) begin
      for (int i = 0; i < 40; i++) check("pkt40_byte", trace[first + i], {1'b0, 8'(8'h40 + i)});
      check("pkt40_com", trace[first + 40], {1'b1, COM});
      for (int i = 1; i <= SC; i++) check("pkt40_skip", trace[first + 40 + i], {1'b1, SKIP});
    end
`endif

    // err_ctrl and scramble-disable pass-through
    send_one('{SKIP, 1'b1, 1'b1, 1'b0}, 1'b1);
    send_one('{COM, 1'b1, 1'b1, 1'b1}, 1'b1);
    send_one('{SKIP, 1'b0, 1'b1, 1'b1}, 1'b0);
    send_one('{8'hF7, 1'b1, 1'b1, 1'b0}, 1'b0);

    // Reset during the second SKIP of an ordered set
    q.delete();
    n = 0;
    drive(1'b0);
    tick(acc);
    while (!(m_skips_left == SC - 2 && dout == SKIP) && n < 200) begin
      drive(1'b0);
      tick(acc);
      n++;
    end
    check("wait_skip2_in_budget", n < 200, 1'b1);
    rst = 1'b1;
    tick(acc);
    check("rst_skp_dout", dout, 8'h00);
    check("rst_skp_k", k_out, 1'b0);
    check("rst_skp_dis", dis_out, 1'b0);
    check("rst_skp_ready", s_ready, 1'b0);
    rst = 1'b0;
    trace.delete();
    run(25, 0, 0, 1);
    check_os_period("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_os_inserter.md
Name: tx_os_inserter

Overview:
- Transmit-side framing stage that sits directly upstream of the 8-bit PCIe-style scrambler and drives its din/k_in/dis_scrambler_in inputs every cycle.
- Accepts a byte stream with packet delimiting over a valid/ready handshake.
- Emits one COM after reset so the scrambler LFSR is synchronised.
- Inserts SKP ordered sets (COM + SKP_COUNT × SKIP) periodically, only between packets, and fills gaps with logical idle (data 8'h00).

Parameters:
- COM, 8'hBC, comma control symbol (K=1); also resets the downstream LFSR.
- SKIP, 8'h1C, skip control symbol (K=1); pauses the downstream LFSR.
- SKP_INTERVAL, 1180, output symbols in DATA state between SKP ordered sets; legal range 8..65535.
- SKP_COUNT, 3, SKIP symbols per ordered set; legal range 1..7.
- IDLE_BYTE, 8'h00, data byte emitted when no payload is available (K=0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream byte valid.
- s_ready  out  1  upstream byte accepted when s_valid && s_ready.
- s_data  in  8  payload byte.
- s_k  in  1  payload byte is a control symbol.
- s_last  in  1  last byte of packet.
- s_dis_scrambler  in  1  pass-through scramble-disable for this byte.
- dout  out  8  symbol to scrambler din.
- k_out  out  1  to scrambler k_in.
- dis_scrambler_out  out  1  to scrambler dis_scrambler_in.
- err_ctrl  out  1  one-cycle pulse: upstream sent COM or SKIP as a control symbol.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: dout=0, k_out=0, dis_scrambler_out=0, err_ctrl=0, state=SYNC, interval counter=0, pending=0, in_pkt=0. s_ready=0 while rst=1.
- All outputs except s_ready are registered. s_ready is combinational: (state==DATA) && !(pending && !in_pkt).
- Latency: a byte accepted in cycle N appears on dout/k_out/dis_scrambler_out in cycle N+1.
- SYNC state:
  - First cycle after rst deasserts: loads COM, k=1, dis=0.
  - Clears the counter and pending, then goes to DATA.
- DATA state, one output symbol loaded per cycle:
  - Accept: load s_data/s_k/s_dis_scrambler. in_pkt <= !s_last.
  - No accept, not inserting: load IDLE_BYTE, k=0, dis=0. in_pkt is unchanged, so an underrun mid-packet emits idle and the packet continues.
  - pending && !in_pkt: load COM k=1, set skp_idx=0, clear counter and pending, go to SKP.
- SKP state:
  - Load SKIP k=1 each cycle. After SKP_COUNT SKIPs go to DATA.
  - Total ordered set = 1 COM + SKP_COUNT SKIP. s_ready=0 throughout.
- Interval counter:
  - Increments once per DATA-state output cycle and saturates at SKP_INTERVAL-1.
  - On reaching SKP_INTERVAL-1, pending is set and held until the COM is emitted.
- Packet boundary: insertion never splits a packet. When pending is set mid-packet, it waits for the s_last byte; insertion starts the cycle after that byte is accepted.
- err_ctrl:
  - Pulses with the output register when an accepted byte has s_k=1 and s_data equals COM or SKIP.
  - The byte is still forwarded unchanged.
- Simultaneous events:
  - pending set in the same cycle as an s_last accept: insertion occurs on the next cycle.
  - s_valid is ignored whenever s_ready=0.
- rst asserted mid-ordered-set or mid-packet: all state is abandoned, outputs return to reset values, and SYNC COM is emitted again after release.

Optional Feature:
- Macro TX_OS_FORCE_EN.
- Defined:
  - A second counter counts cycles while pending && in_pkt.
  - When it reaches SKP_INTERVAL, the ordered set is inserted immediately, mid-packet: s_ready drops the same cycle and in_pkt is preserved across the ordered set.
  - The second counter clears on insertion.
- Undefined: insertion waits indefinitely for the packet boundary, and no second counter exists.

Test Plan:
- Reset then release with s_valid=0 and SKP_INTERVAL=16 -> cycle 1: dout=BC k=1; cycles 2-16: 00 k=0; then BC,1C,1C,1C with k=1; then idle resumes.
- Continuous 4-byte packets 11,22,33,44 (s_last on 44), SKP_INTERVAL=16 -> bytes appear 1 cycle after accept. SKP ordered sets only follow a 44. s_ready=0 for exactly 4 cycles per insertion. No byte is lost or duplicated.
- A 40-byte packet with pending set at byte 10, macro undefined -> all 40 bytes are contiguous, then BC,1C,1C,1C.
- Same 40-byte packet with TX_OS_FORCE_EN defined and SKP_INTERVAL=16 -> ordered set inserted mid-packet 16 cycles after pending. Remaining bytes follow in order.
- Accepted byte s_k=1, s_data=1C -> dout=1C k=1 and err_ctrl=1 for one cycle. A byte with s_dis_scrambler=1 produces dis_scrambler_out=1 in the same output cycle.
- rst=1 during the second SKIP of an ordered set -> next cycle outputs 0/0/0, s_ready=0. After release: BC k=1, then counter restarts from 0.
